// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, the BCD saturation digit and a width helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Number of bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with a start/done handshake and saturation to all nines on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_wr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_wr[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit after adjustment means the value no
    // longer fits in DIGITS decimal digits; it is remembered in ovf_acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            bin_sr   <= '0;
            bcd_wr   <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        bcd_wr  <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_wr  <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ovf_acc) begin
                        bcd_out  <= {DIGITS{BCD_NINE}};
                        overflow <= 1'b1;
                    end else begin
                        bcd_out  <= bcd_wr;
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values,
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int BIN_W   = 32;
    localparam int DIGITS  = 4;
    localparam int LATENCY = BIN_W + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [BIN_W-1:0]     bin_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 overflow;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain decimal arithmetic, saturating at 10^DIGITS - 1.
    function automatic void refModel(input logic [BIN_W-1:0] v,
                                     output logic [4*DIGITS-1:0] bcd,
                                     output logic ovf);
        longint unsigned x;
        longint unsigned limit;
        limit = 1;
        for (int i = 0; i < DIGITS; i++) limit = limit * 10;
        x   = longint'(v);
        ovf = (x >= limit);
        if (ovf) x = limit - 1;
        bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: accept, wait for done, check latency/busy/result.
    task automatic applyStimulus(input logic [BIN_W-1:0] value, input string tag);
        logic [4*DIGITS-1:0] exp_bcd;
        logic                exp_ovf;
        int cycles;
        int busy_cycles;
        refModel(value, exp_bcd, exp_ovf);
        @(negedge clk);
        start  = 1'b1;
        bin_in = value;
        tick();
        start  = 1'b0;
        bin_in = $urandom;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        cycles      = 0;
        busy_cycles = 1;
        while (!done && cycles < 100) begin
            tick();
            bin_in = $urandom;
            cycles++;
            if (busy) busy_cycles++;
        end
        checkOutput({tag, "_lat"}, 32'(cycles), 32'(LATENCY));
        checkOutput({tag, "_busylen"}, 32'(busy_cycles), 32'(LATENCY));
        checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        tick();
        checkOutput({tag, "_donew"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_count;
        int last_done;
        logic prev_done;
        logic [BIN_W-1:0] r;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed conversions");
        applyStimulus(32'd0, "zero");
        applyStimulus(32'd1234, "v1234");
        applyStimulus(32'd6, "v6");
        applyStimulus(32'd9999, "v9999");
        applyStimulus(32'd10000, "v10000");
        applyStimulus(32'hFFFF_FFFF, "vmax");

        $display("[TB] start during busy ignored");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd42;
        tick();
        done_count = 0;
        for (int c = 1; c <= 40; c++) begin
            start  = (c == 5);
            bin_in = (c == 5) ? 32'd77 : $urandom;
            tick();
            if (done) begin
                done_count++;
                checkOutput("busy_start_bcd", 32'(bcd_out), 32'h0042);
                checkOutput("busy_start_lat", 32'(c), 32'(LATENCY));
            end
        end
        start = 1'b0;
        checkOutput("busy_start_cnt", 32'(done_count), 32'd1);
        applyStimulus(32'd305, "after_busy");

        $display("[TB] reset mid-conversion");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd555;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_bcd", 32'(bcd_out), 32'd0);
        checkOutput("abort_ovf", 32'(overflow), 32'd0);
        done_count = 0;
        repeat (2) begin
            tick();
            if (done) done_count++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) done_count++;
        end
        checkOutput("abort_nodone", 32'(done_count), 32'd0);
        applyStimulus(32'd81, "v81");

        $display("[TB] start held high");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'd99;
        done_count = 0;
        last_done  = -1;
        prev_done  = 1'b0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (done) begin
                checkOutput("held_width", 32'(prev_done), 32'd0);
                checkOutput("held_bcd", 32'(bcd_out), 32'h0099);
                if (last_done >= 0)
                    checkOutput("held_period", 32'(c - last_done), 32'(LATENCY + 1));
                last_done = c;
                done_count++;
            end
            prev_done = done;
        end
        start = 1'b0;
        checkOutput("held_count", 32'(done_count), 32'd3);
        for (int c = 0; c < 50 && busy; c++) tick();
        tick();

        $display("[TB] random conversions");
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0:       r = $urandom_range(0, 9999);
                1:       r = $urandom_range(9990, 10010);
                2:       r = $urandom_range(0, 200000);
                default: r = $urandom;
            endcase
            applyStimulus(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
